// File: rtl/alu_dispatch_pkg.sv
// rtl/alu_dispatch_pkg.sv - shared constants and FSM state type for the ALU dispatch block
package alu_dispatch_pkg;

  localparam logic [1:0] CLS_ARITH = 2'b00;
  localparam logic [1:0] CLS_LOGIC = 2'b01;
  localparam logic [1:0] CLS_SHIFT = 2'b11;
  localparam logic [1:0] CLS_RSVD  = 2'b10;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_dispatch_decode.sv
// rtl/alu_dispatch_decode.sv - opcode decode into unit select, sub-op and illegal flag
module alu_dispatch_decode
  import alu_dispatch_pkg::*;
(
  input  logic [3:0] op_i,
  output logic [1:0] sel_o,
  output logic [1:0] sub_op_o,
  output logic       illegal_o
);

  always_comb begin
    sel_o     = op_i[3:2];
    sub_op_o  = op_i[1:0];
    illegal_o = 1'b0;
    case (op_i[3:2])
      CLS_ARITH, CLS_LOGIC, CLS_SHIFT: illegal_o = 1'b0;
      CLS_RSVD:                        illegal_o = 1'b1;
      default:                         illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_dispatch.sv
// rtl/alu_dispatch.sv - issue-side sequencer: accept op, drive ALU, wait LAT, return result
// Optional ALU_DISPATCH_FLAGS_EN adds registered zero/negative result flags.
module alu_dispatch
  import alu_dispatch_pkg::*;
#(
  parameter int unsigned N   = 8,
  parameter int unsigned LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   in_op,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [1:0]   alu_sub_op,
  output logic         s0,
  output logic         s1,
  input  logic [N-1:0] alu_rc,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_result,
  output logic         err_illegal
`ifdef ALU_DISPATCH_FLAGS_EN
  ,
  output logic         flag_zero,
  output logic         flag_neg
`endif
);

  if (LAT > ((1 << CNT_W) - 1)) begin : g_lat_range
    $error("alu_dispatch: LAT must be in 0..15");
  end

  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(LAT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     a_q, a_d, b_q, b_d, res_q, res_d;
  logic [1:0]       sub_q, sub_d, sel_q, sel_d;
  logic             rdy_q, rdy_d, err_q, err_d;
  logic [1:0]       dec_sel, dec_sub;
  logic             dec_illegal;
  logic             capture;

  alu_dispatch_decode u_decode (
    .op_i      (in_op),
    .sel_o     (dec_sel),
    .sub_op_o  (dec_sub),
    .illegal_o (dec_illegal)
  );

  assign capture = (state_q == WAIT) && (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    sel_d   = sel_q;
    res_d   = res_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // rdy_q gates acceptance so nothing is taken on the first cycle out of reset
        if (in_valid && rdy_q) begin
          if (dec_illegal) begin
            err_d = 1'b1;
          end else begin
            a_d     = in_a;
            b_d     = in_b;
            sub_d   = dec_sub;
            sel_d   = dec_sel;
            cnt_d   = LAT_CNT;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (capture) begin
          res_d   = alu_rc;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= '0;
      sel_q   <= '0;
      res_q   <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      sel_q   <= sel_d;
      res_q   <= res_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
    end
  end

`ifdef ALU_DISPATCH_FLAGS_EN
  logic zero_q, neg_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else if (capture) begin
      zero_q <= (alu_rc == '0);
      neg_q  <= alu_rc[N-1];
    end
  end

  assign flag_zero = zero_q;
  assign flag_neg  = neg_q;
`endif

  assign in_ready    = rdy_q;
  assign out_valid   = (state_q == DONE);
  assign out_result  = res_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_sub_op  = sub_q;
  assign s1          = sel_q[1];
  assign s0          = sel_q[0];
  assign err_illegal = err_q;

endmodule

// File: doc/alu_dispatch.md
# alu_dispatch

Issue-side sequencer for the 8-bit ALU datapath. Accepts one operation per valid/ready handshake, decodes the opcode into the unit-select lines `{s1,s0}` and a unit sub-op, and holds registered operands on the ALU inputs. It waits a fixed settle latency, captures the ALU result `RC`, and returns it on a valid/ready output port. It sits between the instruction/test front end and the ALU's arithmetic/logic/shifter/result-mux cluster.

## Interface
- `N`, default 8: operand and result width.
- `LAT`, default 1: extra settle cycles before capturing `alu_rc`; range 0..15.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `in_valid` input 1: operation offered.
- `in_ready` output 1: block can accept.
- `in_op` input 4: `[3:2]` unit class, `[1:0]` sub-op.
- `in_a`, `in_b` input N: signed operands.
- `alu_a`, `alu_b` output N: registered operands to the ALU units.
- `alu_sub_op` output 2: registered sub-op to the selected unit.
- `s0`, `s1` output 1: registered unit select to the result mux.
- `alu_rc` input N: signed ALU result.
- `out_valid` output 1: result available.
- `out_ready` input 1: consumer accepts the result.
- `out_result` output N: captured result.
- `err_illegal` output 1: one-cycle pulse on a reserved opcode.
- `flag_zero`, `flag_neg` output 1: present only under `ALU_DISPATCH_FLAGS_EN`.

## Operation
- Unit class encoding: `00` arithmetic, `01` logic, `11` shifter, `10` reserved.
- FSM states and transitions:
  - IDLE: `in_ready`=1. On `in_valid`:
    - Class `10`: pulse `err_illegal` for one cycle and stay in IDLE. No ALU outputs change and no result is produced.
    - Otherwise: latch `in_a`, `in_b` and `in_op[1:0]`, drive `{s1,s0}` = class, load the counter with `LAT`, go to WAIT.
  - WAIT: `in_ready`=0. If counter==0, capture `alu_rc` into `out_result` and go to DONE. Otherwise decrement the counter.
  - DONE: `out_valid`=1. On `out_ready`, go to IDLE.
- `alu_a`, `alu_b`, `alu_sub_op` and `{s1,s0}` stay stable from acceptance until the next accepted operation. They are not cleared on returning to IDLE.
- `out_result` is stable while `out_valid && !out_ready`.
- `in_ready` is asserted only in IDLE. There is no acceptance during WAIT or DONE.
- A reserved opcode that arrives while busy is not accepted and is not flagged.
- Counter width is 4 bits. `LAT`>15 is a parameter error and must be rejected by elaboration-time assertion.

## Timing
- Reset: state IDLE. The following outputs are 0 after reset:
  - `in_ready` is the exception: it is 1 one cycle after reset release.
  - All other outputs are 0: `out_valid`, `out_result`, `alu_a`, `alu_b`, `alu_sub_op`, `s0`, `s1`, `err_illegal` and both flags.
- Acceptance at edge T gives `out_valid`=1 from edge T+1+LAT, so latency is `LAT`+1 cycles.
- Output handshake at edge D returns to IDLE at D. The earliest next acceptance is edge D+1.
- `err_illegal` is high for exactly the cycle after the edge that sampled the reserved opcode.
- Reset asserted mid-WAIT or mid-DONE abandons the transaction. The pending result is never presented.

## Configuration
- `ALU_DISPATCH_FLAGS_EN` defined:
  - `flag_zero` = (captured result == 0).
  - `flag_neg` = captured result MSB.
  - Both flags are registered with `out_result` and held alongside it.
- `ALU_DISPATCH_FLAGS_EN` undefined: the flag ports and logic are absent.

## Structure
- Package `alu_dispatch_pkg`:
  - Unit-class constants `CLS_ARITH`=2'b00, `CLS_LOGIC`=2'b01, `CLS_SHIFT`=2'b11, `CLS_RSVD`=2'b10.
  - FSM state type IDLE/WAIT/DONE.
- Sub-module `alu_dispatch_decode`: combinational. Maps `in_op` to `{s1,s0}`, sub-op and an illegal flag.

## Test plan
- Reset, `LAT`=1: hold `rst_n`=0 for 3 cycles. After release, all outputs are 0 and `in_ready`=1.
- Arithmetic op: `in_op`=4'b0001, `a`=8'd20, `b`=8'd5, bench ALU model returns 25. Expect `{s1,s0}`=00, `alu_sub_op`=01, and `out_valid` exactly 2 cycles after accept with `out_result`=25.
- Shifter op with backpressure: `in_op`=4'b1100, `out_ready` held low for 4 cycles. Expect `out_result` stable, `in_ready`=0 throughout, and acceptance one cycle after the handshake.
- Reserved op: `in_op`=4'b1000. Expect a one-cycle `err_illegal`, no `out_valid`, `{s1,s0}` unchanged from the prior op, and `in_ready` still 1.
- Reset mid-WAIT with `LAT`=3: assert `rst_n`=0 one cycle after accept. Expect no `out_valid` ever for that op and clean acceptance afterwards.
- With `ALU_DISPATCH_FLAGS_EN` defined: result 8'h80 gives `flag_neg`=1 and `flag_zero`=0; result 0 gives `flag_zero`=1.
